knight_rider_checker: RTL and testbench
=======================================

KNIGHT_RIDER_CHECKER -- requirements
Module: knight_rider_checker

Interface
REQ-001 Parameter TICKS_PER_STATE, default 32'd40_000_000: nominal dwell, in clk cycles, of each LED state.
REQ-002 Parameter TOLERANCE, default 32'd1000: allowed +/- dwell deviation in cycles.
REQ-003 Parameter LOCK_COUNT, default 8'd4: consecutive good transitions required for lock.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 led_in  input  3  observed LED vector (bouncing one-hot pattern).
REQ-007 locked  output  1  pattern tracked with at least LOCK_COUNT consecutive good transitions.
REQ-008 err  output  1  one-cycle pulse on each detected violation.
REQ-009 err_code  output  2  cause of the last error: 0 illegal, 1 sequence, 2 short dwell, 3 long dwell; held until the next error.
REQ-010 err_cnt  output  16  total errors; saturates at 16'hFFFF.
REQ-011 sweep_cnt  output  16  completed sweeps; wraps modulo 2^16.
REQ-012 dwell_last  output  32  dwell, in cycles, of the most recently completed LED state.

Function
REQ-013 Sample path: led_s is the conditioned input (see REQ-030/031); led_prev is led_s delayed by one cycle; a change is the condition led_s != led_prev.
REQ-014 Dwell counter cnt is cleared to 1 on a change cycle and otherwise increments, saturating at 32'hFFFF_FFFF.
REQ-015 On every change, dwell_last <= cnt.
REQ-016 Legal values: 3'b001, 3'b010, 3'b100.
REQ-017 Legal sequence is 001->010->100->010->001, repeating.
  - Direction register dir: UP = shift left, DOWN = shift right.
  - dir flips on entering 100 (to DOWN) and on entering 001 (to UP).
REQ-018 States: S_ACQUIRE, S_TRACK.
REQ-019 In S_ACQUIRE:
  - err is never raised.
  - On a change where both led_prev and led_s are legal and adjacent, set dir from that step and go to S_TRACK.
  - The dwell of that first step is not checked.
  - The good-transition count is set to 1.
REQ-020 In S_TRACK, each change is checked in this priority order:
  - led_s not legal -> code 0;
  - led_s is not the expected next value for dir -> code 1;
  - cnt < TICKS_PER_STATE-TOLERANCE -> code 2;
  - cnt > TICKS_PER_STATE+TOLERANCE -> code 3.
REQ-021 In S_TRACK with no change, when cnt reaches TICKS_PER_STATE+TOLERANCE+1, raise code 3 immediately (timeout).
REQ-022 A timeout and a change in the same cycle are evaluated as a change only; a single error is raised.
REQ-023 On any error:
  - err=1 for exactly one cycle, in the cycle after detection;
  - err_code updated;
  - err_cnt incremented (saturating);
  - locked=0; good-transition count cleared;
  - state -> S_ACQUIRE.
REQ-024 A good transition increments the good-transition count (saturating at 255); locked=1 when the count >= LOCK_COUNT.
REQ-025 sweep_cnt increments on each good S_TRACK transition 010->001.
REQ-026 The comparison bounds are computed at 33-bit width; TICKS_PER_STATE-TOLERANCE underflow clamps to 0.

Reset
REQ-027 rst has priority over all other logic.
REQ-028 Reset values:
  - state=S_ACQUIRE, dir=UP, cnt=1;
  - led_prev=0, synchronizer flops=0;
  - locked=0, err=0, err_code=0;
  - err_cnt=0, sweep_cnt=0, dwell_last=0.
REQ-029 rst asserted mid-sweep discards all history; after release, tracking restarts from S_ACQUIRE with no error reported.

Configuration
REQ-030 With macro KR_CHECK_SYNC_EN defined, led_in passes through a 2-flop synchronizer; led_s lags led_in by 2 cycles.
REQ-031 Without KR_CHECK_SYNC_EN, led_s = led_in registered once (1-cycle lag); all other behaviour is identical.

Structure
REQ-032 Shared package kr_pkg holds:
  - state encodings S_ACQUIRE/S_TRACK;
  - direction constants;
  - error-code constants ERR_ILLEGAL/ERR_SEQ/ERR_SHORT/ERR_LONG;
  - the legal LED value constants.
REQ-033 One sub-module, kr_sync2: a generic-width 2-flop synchronizer with synchronous reset, instantiated only under KR_CHECK_SYNC_EN.

Verification
Parameters for all scenarios: TICKS_PER_STATE=10, TOLERANCE=1, LOCK_COUNT=4.
REQ-034 Ideal pattern, 10 cycles per state, for 3 full sweeps:
  - locked rises after the 4th good transition;
  - sweep_cnt=3 (or 2 if the first 010->001 occurs in S_ACQUIRE);
  - err never asserted; dwell_last=10.
REQ-035 Locked, then 001->100:
  - err pulse, err_code=1, err_cnt=1, locked=0;
  - re-lock after 4 further good transitions.
REQ-036 Locked, hold one state 8 cycles -> err_code=2; separately hold 11 cycles -> no error (inside tolerance).
REQ-037 Locked, freeze led_in at 010:
  - err_code=3 exactly when cnt reaches 12, with no change;
  - no further errors while in S_ACQUIRE.
REQ-038 Locked, drive 3'b011:
  - err_code=0;
  - then drive 000 while in S_ACQUIRE -> no error.
REQ-039 Assert rst mid-sweep for 1 cycle:
  - all outputs return to reset values;
  - re-lock follows with err_cnt=0;
  - repeat both with and without KR_CHECK_SYNC_EN, and check the 2-cycle vs 1-cycle lag of dwell_last updates.

Source files
------------

// File: rtl/kr_pkg.sv
// kr_pkg: shared constants for the knight rider pattern checker.
// Holds FSM states, direction, error codes and legal LED values.
package kr_pkg;

    typedef enum logic {
        S_ACQUIRE = 1'b0,
        S_TRACK   = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [1:0] ERR_ILLEGAL = 2'd0;
    localparam logic [1:0] ERR_SEQ     = 2'd1;
    localparam logic [1:0] ERR_SHORT   = 2'd2;
    localparam logic [1:0] ERR_LONG    = 2'd3;

    localparam logic [2:0] LED_L = 3'b001;
    localparam logic [2:0] LED_M = 3'b010;
    localparam logic [2:0] LED_R = 3'b100;

    function automatic logic is_legal(input logic [2:0] v);
        return (v == LED_L) || (v == LED_M) || (v == LED_R);
    endfunction

endpackage

// File: rtl/kr_sync2.sv
// kr_sync2: generic-width 2-flop synchronizer, synchronous active-high reset.
// Ports: clk, rst, d[WIDTH-1:0] async input, q[WIDTH-1:0] synchronized output.
module kr_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/knight_rider_checker.sv
// knight_rider_checker: checks a bouncing one-hot LED pattern for value, order and dwell.
// Ports: clk, rst (sync, active-high), led_in[2:0]; locked, err, err_code[1:0],
// err_cnt[15:0], sweep_cnt[15:0], dwell_last[31:0]. Macro KR_CHECK_SYNC_EN adds a 2-flop sync.
module knight_rider_checker
    import kr_pkg::*;
#(
    parameter logic [31:0] TICKS_PER_STATE = 32'd40_000_000,
    parameter logic [31:0] TOLERANCE       = 32'd1000,
    parameter logic [7:0]  LOCK_COUNT      = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  led_in,
    output logic        locked,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] err_cnt,
    output logic [15:0] sweep_cnt,
    output logic [31:0] dwell_last
);

    // Dwell bounds at 33 bits so the sum cannot wrap; lower bound clamps at 0.
    localparam logic [32:0] HI_B = {1'b0, TICKS_PER_STATE} + {1'b0, TOLERANCE};
    localparam logic [32:0] LO_B = (TICKS_PER_STATE >= TOLERANCE) ?
                                   ({1'b0, TICKS_PER_STATE} - {1'b0, TOLERANCE}) : 33'd0;
    localparam logic [32:0] TO_B = HI_B + 33'd1;

    logic [2:0] led_s;

`ifdef KR_CHECK_SYNC_EN
    kr_sync2 #(.WIDTH(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (led_in),
        .q   (led_s)
    );
`else
    logic [2:0] led_s_q, led_s_d;

    always_comb led_s_d = led_in;

    always_ff @(posedge clk) begin
        if (rst) led_s_q <= '0;
        else     led_s_q <= led_s_d;
    end

    assign led_s = led_s_q;
`endif

    state_e      state_q, state_d;
    dir_e        dir_q, dir_d, dir_new;
    logic [2:0]  led_prev_q, led_prev_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  good_q, good_d, good_inc;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] sweep_cnt_q, sweep_cnt_d;
    logic [31:0] dwell_last_q, dwell_last_d;

    logic        change, fault;
    logic [1:0]  fault_code;
    logic [2:0]  step_up_v, step_dn_v, expect_v;
    logic [32:0] cnt_x;

    assign cnt_x     = {1'b0, cnt_q};
    assign step_up_v = {led_prev_q[1:0], 1'b0};
    assign step_dn_v = {1'b0, led_prev_q[2:1]};
    assign expect_v  = (dir_q == DIR_UP) ? step_up_v : step_dn_v;
    assign good_inc  = (good_q == 8'hFF) ? good_q : good_q + 8'd1;

    // Direction after a legal step: the ends force the bounce, the middle follows the step.
    always_comb begin
        if (led_s == LED_R)          dir_new = DIR_DOWN;
        else if (led_s == LED_L)     dir_new = DIR_UP;
        else if (led_s == step_up_v) dir_new = DIR_UP;
        else                         dir_new = DIR_DOWN;
    end

    always_comb begin
        change       = (led_s != led_prev_q);
        led_prev_d   = led_s;
        cnt_d        = change ? 32'd1 :
                       (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        dwell_last_d = change ? cnt_q : dwell_last_q;
        state_d      = state_q;
        dir_d        = dir_q;
        good_d       = good_q;
        locked_d     = locked_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        err_cnt_d    = err_cnt_q;
        sweep_cnt_d  = sweep_cnt_q;
        fault        = 1'b0;
        fault_code   = ERR_ILLEGAL;

        unique case (state_q)
            S_ACQUIRE: begin
                if (change && is_legal(led_prev_q) && is_legal(led_s) &&
                    ((led_s == step_up_v) || (led_s == step_dn_v))) begin
                    state_d  = S_TRACK;
                    dir_d    = dir_new;
                    good_d   = 8'd1;
                    locked_d = (8'd1 >= LOCK_COUNT);
                end
            end
            S_TRACK: begin
                if (change) begin
                    if (!is_legal(led_s)) begin
                        fault      = 1'b1;
                        fault_code = ERR_ILLEGAL;
                    end else if (led_s != expect_v) begin
                        fault      = 1'b1;
                        fault_code = ERR_SEQ;
                    end else if (cnt_x < LO_B) begin
                        fault      = 1'b1;
                        fault_code = ERR_SHORT;
                    end else if (cnt_x > HI_B) begin
                        fault      = 1'b1;
                        fault_code = ERR_LONG;
                    end else begin
                        dir_d    = dir_new;
                        good_d   = good_inc;
                        locked_d = (good_inc >= LOCK_COUNT);
                        if (led_prev_q == LED_M && led_s == LED_L)
                            sweep_cnt_d = sweep_cnt_q + 16'd1;
                    end
                end else if (cnt_x == TO_B) begin
                    // State held too long: flag it now rather than wait for a change.
                    fault      = 1'b1;
                    fault_code = ERR_LONG;
                end
            end
        endcase

        if (fault) begin
            err_d      = 1'b1;
            err_code_d = fault_code;
            err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            locked_d   = 1'b0;
            good_d     = 8'd0;
            state_d    = S_ACQUIRE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ACQUIRE;
            dir_q        <= DIR_UP;
            led_prev_q   <= '0;
            cnt_q        <= 32'd1;
            good_q       <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_ILLEGAL;
            err_cnt_q    <= '0;
            sweep_cnt_q  <= '0;
            dwell_last_q <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            led_prev_q   <= led_prev_d;
            cnt_q        <= cnt_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_cnt_q    <= err_cnt_d;
            sweep_cnt_q  <= sweep_cnt_d;
            dwell_last_q <= dwell_last_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_cnt    = err_cnt_q;
    assign sweep_cnt  = sweep_cnt_q;
    assign dwell_last = dwell_last_q;

endmodule

// File: tb/tb_knight_rider_checker.sv
// tb_knight_rider_checker: self-checking bench for knight_rider_checker.
// Reference model tracks position in the 001,010,100,010 cycle; honours KR_CHECK_SYNC_EN lag.
module tb_knight_rider_checker;

`ifdef KR_CHECK_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 1;
`endif
    localparam int TPS  = 10;
    localparam int TOL  = 1;
    localparam int LOCK = 4;
    localparam int LO   = (TPS >= TOL) ? TPS - TOL : 0;
    localparam int HI   = TPS + TOL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  led_in = 3'b000;
    logic        locked, err;
    logic [1:0]  err_code;
    logic [15:0] err_cnt, sweep_cnt;
    logic [31:0] dwell_last;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    bit sb_en = 1'b0;

    logic [2:0] seq [4] = '{3'b001, 3'b010, 3'b100, 3'b010};
    logic [2:0] ill [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    // Reference model state
    logic [2:0]  m_p1, m_s, m_p;
    int          m_e, m_pos, m_good;
    bit          m_trk;
    logic        x_lock, x_err;
    logic [1:0]  x_code;
    logic [15:0] x_ecnt, x_sweep;
    logic [31:0] x_dwell;

    always #5 clk = ~clk;

    knight_rider_checker #(
        .TICKS_PER_STATE (32'd10),
        .TOLERANCE       (32'd1),
        .LOCK_COUNT      (8'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .locked     (locked),
        .err        (err),
        .err_code   (err_code),
        .err_cnt    (err_cnt),
        .sweep_cnt  (sweep_cnt),
        .dwell_last (dwell_last)
    );

    function automatic bit legal(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    always @(posedge clk) begin : ref_model
        int e, pos, good, ecnt, sweep, fault;
        bit trk, lk;
        logic [1:0] code;
        logic [31:0] dw;
        if (rst) begin
            m_p1 <= '0; m_s <= '0; m_p <= '0;
            m_e <= 1; m_pos <= 0; m_good <= 0; m_trk <= 1'b0;
            x_lock <= 1'b0; x_err <= 1'b0; x_code <= '0;
            x_ecnt <= '0; x_sweep <= '0; x_dwell <= '0;
        end else begin
            e = m_e; pos = m_pos; good = m_good; trk = m_trk;
            lk = x_lock; code = x_code; dw = x_dwell;
            ecnt = int'(x_ecnt); sweep = int'(x_sweep);
            fault = -1;
            if (m_s != m_p) begin
                dw = 32'(e);
                if (!trk) begin
                    if (legal(m_p) && legal(m_s) &&
                        (int'(m_s) == 2 * int'(m_p) ||
                         int'(m_p) == 2 * int'(m_s))) begin
                        trk = 1'b1; good = 1; lk = (good >= LOCK);
                        if (m_s == 3'b001)      pos = 0;
                        else if (m_s == 3'b100) pos = 2;
                        else                    pos = (m_p == 3'b001) ? 1 : 3;
                    end
                end else if (!legal(m_s)) fault = 0;
                else if (m_s != seq[(pos + 1) % 4]) fault = 1;
                else if (e < LO) fault = 2;
                else if (e > HI) fault = 3;
                else begin
                    pos = (pos + 1) % 4;
                    if (good < 255) good++;
                    lk = (good >= LOCK);
                    if (pos == 0) sweep = (sweep + 1) % 65536;
                end
                e = 1;
            end else begin
                if (trk && e == HI + 1) fault = 3;
                if (e < 32'h7FFF_FFFF) e++;
            end
            if (fault >= 0) begin
                code = 2'(fault);
                if (ecnt < 65535) ecnt++;
                lk = 1'b0; good = 0; trk = 1'b0;
            end
            m_e <= e; m_pos <= pos; m_good <= good; m_trk <= trk;
            x_lock <= lk; x_err <= (fault >= 0); x_code <= code;
            x_ecnt <= 16'(ecnt); x_sweep <= 16'(sweep); x_dwell <= dw;
            m_p <= m_s;
            if (LAG == 2) begin
                m_s  <= m_p1;
                m_p1 <= led_in;
            end else begin
                m_s <= led_in;
            end
        end
    end

    always @(negedge clk) begin
        if (err === 1'b1) err_seen++;
        if (sb_en) begin
            n_cmp++;
            if ({locked, err, err_code, err_cnt, sweep_cnt, dwell_last} !==
                {x_lock, x_err, x_code, x_ecnt, x_sweep, x_dwell}) begin
                n_bad++;
                $display("FAIL model t=%0t got l=%0b e=%0b c=%0d ec=%0d sw=%0d dw=%0d want l=%0b e=%0b c=%0d ec=%0d sw=%0d dw=%0d",
                         $time, locked, err, err_code, err_cnt, sweep_cnt, dwell_last,
                         x_lock, x_err, x_code, x_ecnt, x_sweep, x_dwell);
            end
        end
    end

    task automatic hold(input logic [2:0] v, input int n);
        led_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic lock_up();
        hold(3'b001, 10);
        hold(3'b010, 10);
        hold(3'b100, 10);
        hold(3'b010, 10);
        hold(3'b001, 10);
    endtask

    task automatic test_reset();
        led_in = 3'b010;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({locked, err, err_code, err_cnt, sweep_cnt, dwell_last} !== '0) begin
            n_bad++;
            $display("FAIL reset_vals got l=%0b e=%0b c=%0d ec=%0d sw=%0d dw=%0d want all 0",
                     locked, err, err_code, err_cnt, sweep_cnt, dwell_last);
        end
        rst = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic test_ideal();
        int e0;
        do_reset();
        e0 = err_seen;
        hold(3'b001, 10);
        hold(3'b010, 10);
        hold(3'b100, 10);
        hold(3'b010, 10);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL ideal_prelock got=%0b want=0", locked);
        end
        hold(3'b001, 10);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL ideal_lock got=%0b want=1", locked);
        end
        for (int k = 0; k < 2; k++) begin
            hold(3'b010, 10);
            hold(3'b100, 10);
            hold(3'b010, 10);
            hold(3'b001, 10);
        end
        n_cmp++;
        if (sweep_cnt !== 16'd3 || dwell_last !== 32'd10) begin
            n_bad++;
            $display("FAIL ideal_sweep got sw=%0d dw=%0d want sw=3 dw=10", sweep_cnt, dwell_last);
        end
        n_cmp++;
        if (err_seen - e0 != 0 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL ideal_noerr got pulses=%0d ec=%0d want 0", err_seen - e0, err_cnt);
        end
    endtask

    task automatic test_seq_err();
        int e0;
        do_reset();
        lock_up();
        e0 = err_seen;
        hold(3'b100, 10);
        n_cmp++;
        if (err_seen - e0 != 1 || err_code !== 2'd1 || err_cnt !== 16'd1 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_err got pulses=%0d c=%0d ec=%0d l=%0b want 1 1 1 0",
                     err_seen - e0, err_code, err_cnt, locked);
        end
        hold(3'b010, 10);
        hold(3'b001, 10);
        hold(3'b010, 10);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_prelock got=%0b want=0", locked);
        end
        hold(3'b100, 10);
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL seq_relock got l=%0b ec=%0d want l=1 ec=1", locked, err_cnt);
        end
    endtask

    task automatic test_dwell();
        do_reset();
        lock_up();
        hold(3'b010, 8);
        hold(3'b100, 10);
        n_cmp++;
        if (err_code !== 2'd2 || err_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL dwell_short got c=%0d ec=%0d want c=2 ec=1", err_code, err_cnt);
        end
        do_reset();
        lock_up();
        hold(3'b010, 11);
        hold(3'b100, 10);
        n_cmp++;
        if (err_cnt !== 16'd0 || locked !== 1'b1 || dwell_last !== 32'd11) begin
            n_bad++;
            $display("FAIL dwell_11 got ec=%0d l=%0b dw=%0d want ec=0 l=1 dw=11",
                     err_cnt, locked, dwell_last);
        end
        hold(3'b010, 9);
        hold(3'b001, 10);
        n_cmp++;
        if (err_cnt !== 16'd0 || dwell_last !== 32'd9) begin
            n_bad++;
            $display("FAIL dwell_9 got ec=%0d dw=%0d want ec=0 dw=9", err_cnt, dwell_last);
        end
    endtask

    task automatic test_timeout();
        int first, e0;
        do_reset();
        lock_up();
        e0 = err_seen;
        first = 0;
        led_in = 3'b010;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (first == 0 && err === 1'b1) first = i;
        end
        n_cmp++;
        if (first != LAG + 13) begin
            n_bad++;
            $display("FAIL timeout_when got=%0d want=%0d", first, LAG + 13);
        end
        n_cmp++;
        if (err_code !== 2'd3 || err_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL timeout_code got c=%0d ec=%0d want c=3 ec=1", err_code, err_cnt);
        end
        hold(3'b010, 40);
        n_cmp++;
        if (err_cnt !== 16'd1 || err_seen - e0 != 1) begin
            n_bad++;
            $display("FAIL timeout_once got ec=%0d pulses=%0d want 1", err_cnt, err_seen - e0);
        end
    endtask

    task automatic test_illegal();
        int e0;
        do_reset();
        lock_up();
        e0 = err_seen;
        hold(3'b011, 10);
        n_cmp++;
        if (err_code !== 2'd0 || err_cnt !== 16'd1 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_code got c=%0d ec=%0d l=%0b want 0 1 0", err_code, err_cnt, locked);
        end
        hold(3'b000, 10);
        hold(3'b010, 10);
        n_cmp++;
        if (err_cnt !== 16'd1 || err_seen - e0 != 1) begin
            n_bad++;
            $display("FAIL illegal_acq got ec=%0d pulses=%0d want 1", err_cnt, err_seen - e0);
        end
    endtask

    task automatic test_mid_reset();
        int first;
        logic [31:0] dv;
        do_reset();
        lock_up();
        hold(3'b100, 10);
        hold(3'b010, 10);
        hold(3'b001, 10);
        hold(3'b010, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        led_in = 3'b001;
        n_cmp++;
        if ({locked, err, err_code, err_cnt, sweep_cnt, dwell_last} !== '0) begin
            n_bad++;
            $display("FAIL midrst_vals got l=%0b e=%0b c=%0d ec=%0d sw=%0d dw=%0d want all 0",
                     locked, err, err_code, err_cnt, sweep_cnt, dwell_last);
        end
        first = 0;
        dv = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (first == 0 && dwell_last !== 32'd0) begin
                first = i;
                dv = dwell_last;
            end
        end
        n_cmp++;
        if (first != LAG + 1 || dv !== 32'(LAG + 1)) begin
            n_bad++;
            $display("FAIL midrst_lag got at=%0d dw=%0d want %0d", first, dv, LAG + 1);
        end
        hold(3'b010, 10);
        hold(3'b100, 10);
        hold(3'b010, 10);
        hold(3'b001, 10);
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL midrst_relock got l=%0b ec=%0d want l=1 ec=0", locked, err_cnt);
        end
    endtask

    task automatic test_random();
        int gp, d, r;
        do_reset();
        gp = 0;
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 15);
            d = $urandom_range(7, 13);
            if (r == 0) begin
                hold(ill[$urandom_range(0, 4)], d);
            end else if (r == 1) begin
                gp = (gp + 2) % 4;
                hold(seq[gp], d);
            end else begin
                gp = (gp + 1) % 4;
                hold(seq[gp], d);
            end
        end
        hold(seq[gp], 4);
        n_cmp++;
        if (err_cnt !== x_ecnt || sweep_cnt !== x_sweep) begin
            n_bad++;
            $display("FAIL random_tot got ec=%0d sw=%0d want ec=%0d sw=%0d",
                     err_cnt, sweep_cnt, x_ecnt, x_sweep);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ideal();
        test_seq_err();
        test_dwell();
        test_timeout();
        test_illegal();
        test_mid_reset();
        test_random();
        sb_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
